// File: rtl/motor_ctrl.sv
// Up/down actuator controller with synchronised, debounced limits, travel timeout and both-limits fault.
// Define MOTOR_CTRL_REVERSE_EN to let activate reverse a travel through a dead-time stop.
module motor_ctrl #(
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1000,
  parameter int DEADTIME = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       activate,
  input  logic       up_limit,
  input  logic       dn_limit,
  input  logic       fault_clr,
  output logic       motor_up,
  output logic       motor_dn,
  output logic       busy,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam int TW  = $clog2(TIMEOUT);
  localparam int DW  = $clog2(DEADTIME + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);
  localparam logic [TW-1:0]  T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [DW-1:0]  D_LAST  = DW'(DEADTIME - 1);

  typedef enum logic [2:0] {S_IDLE, S_UP, S_DN, S_STOP, S_FAULT} state_t;

  state_t         r_state, w_next;
  logic [1:0]     r_code, w_code_nxt;
  logic [TW-1:0]  r_timer;
  logic [DW-1:0]  r_dead;
  logic           r_pend_up;

  logic           r_act_s1, r_act_s2, r_act_d, r_warm, r_act_arm;
  logic [1:0]     r_lim_s1, r_lim_s2, r_lim_f;
  logic [DBW-1:0] r_db_cnt [2];
  logic           w_act_pulse, w_up_f, w_dn_f, w_both;

  // r_act_arm blocks a rising edge that is only an artefact of reset while activate is held high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act_s1  <= 1'b0;
      r_act_s2  <= 1'b0;
      r_act_d   <= 1'b0;
      r_warm    <= 1'b0;
      r_act_arm <= 1'b0;
    end else begin
      r_act_s1  <= activate;
      r_act_s2  <= r_act_s1;
      r_act_d   <= r_act_s2;
      r_warm    <= 1'b1;
      r_act_arm <= r_act_arm | (r_warm & ~r_act_s1);
    end
  end

  assign w_act_pulse = r_act_s2 & ~r_act_d & r_act_arm;

  // index 0 = top limit, index 1 = bottom limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lim_s1 <= 2'b00;
      r_lim_s2 <= 2'b00;
      r_lim_f  <= 2'b00;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_lim_s1 <= {dn_limit, up_limit};
      r_lim_s2 <= r_lim_s1;
      for (int i = 0; i < 2; i++) begin
        if (r_lim_s2[i] == r_lim_f[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_lim_f[i]  <= ~r_lim_f[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_up_f = r_lim_f[0];
  assign w_dn_f = r_lim_f[1];
  assign w_both = w_up_f & w_dn_f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_code    <= 2'b00;
      r_timer   <= '0;
      r_dead    <= '0;
      r_pend_up <= 1'b0;
    end else begin
      r_state <= w_next;
      r_code  <= w_code_nxt;
      if (w_next != r_state)
        r_timer <= '0;
      else if (r_state == S_UP || r_state == S_DN)
        r_timer <= r_timer + 1'b1;
      if (w_next != r_state)
        r_dead <= '0;
      else if (r_state == S_STOP)
        r_dead <= r_dead + 1'b1;
      if (w_next == S_STOP && r_state != S_STOP)
        r_pend_up <= (r_state == S_DN);
    end
  end

  always_comb begin
    w_next     = r_state;
    w_code_nxt = r_code;
    case (r_state)
      S_IDLE: begin
        if (w_both) begin
          w_next     = S_FAULT;
          w_code_nxt = 2'b10;
        end else if (w_act_pulse) begin
          w_next = w_up_f ? S_DN : S_UP;
        end
      end
      S_UP, S_DN: begin
        if (w_both) begin
          w_next     = S_FAULT;
          w_code_nxt = 2'b10;
        end else if ((r_state == S_UP) ? w_up_f : w_dn_f) begin
          w_next = S_IDLE;
        end else if (r_timer == T_LAST) begin
          w_next     = S_FAULT;
          w_code_nxt = 2'b01;
        end
`ifdef MOTOR_CTRL_REVERSE_EN
        else if (w_act_pulse) begin
          w_next = S_STOP;
        end
`endif
      end
      // only reachable when reversal is compiled in
      S_STOP: begin
        if (w_both) begin
          w_next     = S_FAULT;
          w_code_nxt = 2'b10;
        end else if (r_dead == D_LAST) begin
          w_next = r_pend_up ? S_UP : S_DN;
        end
      end
      S_FAULT: begin
        if (fault_clr && !w_both) begin
          w_next     = S_IDLE;
          w_code_nxt = 2'b00;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    motor_up   = (r_state == S_UP);
    motor_dn   = (r_state == S_DN);
    busy       = (r_state == S_UP) || (r_state == S_DN) || (r_state == S_STOP);
    fault      = (r_state == S_FAULT);
    fault_code = r_code;
  end

endmodule

// File: tb/tb_motor_ctrl.sv
// Self-checking bench for motor_ctrl: directed timing scenarios plus a randomized soak
// compared against a cycle-level behavioural model of the controller's rules.
module tb_motor_ctrl;

  localparam int DEB = 4;
  localparam int TMO = 16;
  localparam int DT  = 8;
`ifdef MOTOR_CTRL_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       activate = 1'b0, up_limit = 1'b0, dn_limit = 1'b0, fault_clr = 1'b0;
  logic       motor_up, motor_dn, busy, fault;
  logic [1:0] fault_code;

  int total = 0;
  int bad   = 0;

  motor_ctrl #(.DEBOUNCE(DEB), .TIMEOUT(TMO), .DEADTIME(DT)) dut (
    .clk(clk), .rst(rst), .activate(activate), .up_limit(up_limit), .dn_limit(dn_limit),
    .fault_clr(fault_clr), .motor_up(motor_up), .motor_dn(motor_dn), .busy(busy),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // Reference model: modes 0 idle, 1 up, 2 down, 3 stop, 4 fault.
  // Raw input samples are kept as histories; the conditioned view at edge n is the sample from edge n-2.
  int m_mode = 0, m_code = 0, m_trav = 0, m_dead = 0, m_n = 0, m_ru = 0, m_rd = 0;
  bit m_pend_up = 0, m_fu = 0, m_fd = 0;
  bit qa[$], qu[$], qd[$];

  task automatic model_reset();
    m_mode = 0; m_code = 0; m_trav = 0; m_dead = 0; m_n = 0; m_ru = 0; m_rd = 0;
    m_pend_up = 0; m_fu = 0; m_fd = 0;
    qa.delete(); qu.delete(); qd.delete();
  endtask

  task automatic model_step();
    bit pulse, su, sd, both;
    int sz;
    m_n++;
    sz = qa.size();
    // a rise counts only when the low before it was genuinely sampled after reset
    pulse = (m_n >= 4) && qa[sz-2] && !qa[sz-3];
    su = (m_n >= 3) ? qu[sz-2] : 1'b0;
    sd = (m_n >= 3) ? qd[sz-2] : 1'b0;
    both = m_fu && m_fd;
    case (m_mode)
      0: if (both) begin m_mode = 4; m_code = 2; end
         else if (pulse) begin m_mode = m_fu ? 2 : 1; m_trav = 0; end
      1, 2: begin
        if (both) begin m_mode = 4; m_code = 2; end
        else if ((m_mode == 1) ? m_fu : m_fd) m_mode = 0;
        else if (m_trav == TMO - 1) begin m_mode = 4; m_code = 1; end
        else if (REV && pulse) begin m_pend_up = (m_mode == 2); m_mode = 3; m_dead = 0; end
        else m_trav++;
      end
      3: if (both) begin m_mode = 4; m_code = 2; end
         else if (m_dead == DT - 1) begin m_mode = m_pend_up ? 1 : 2; m_trav = 0; end
         else m_dead++;
      default: if (fault_clr && !both) begin m_mode = 0; m_code = 0; end
    endcase
    if (su != m_fu) begin m_ru++; if (m_ru == DEB) begin m_fu = !m_fu; m_ru = 0; end end
    else m_ru = 0;
    if (sd != m_fd) begin m_rd++; if (m_rd == DEB) begin m_fd = !m_fd; m_rd = 0; end end
    else m_rd = 0;
    qa.push_back(activate); qu.push_back(up_limit); qd.push_back(dn_limit);
    if (qa.size() > 4) begin void'(qa.pop_front()); void'(qu.pop_front()); void'(qd.pop_front()); end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_act();
    activate = 1'b1;
    tick();
    activate = 1'b0;
  endtask

  task automatic clear_fault();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    total++;
    if ({fault, fault_code, busy} !== 4'b0000) begin
      bad++; $display("FAIL fault_clear: fault/code/busy=%b exp 0000", {fault, fault_code, busy});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++;
    if ({motor_up, motor_dn, busy, fault, fault_code} !== 6'b0) begin
      bad++; $display("FAIL reset_outputs: got=%b exp 000000", {motor_up, motor_dn, busy, fault, fault_code});
    end
    rst = 1'b0;
    repeat (5) tick();
    total++;
    if ({motor_up, motor_dn, busy, fault, fault_code} !== 6'b0) begin
      bad++; $display("FAIL reset_idle: got=%b exp 000000", {motor_up, motor_dn, busy, fault, fault_code});
    end
  endtask

  task automatic test_raise();
    pulse_act();
    tick();
    total++;
    if (motor_up !== 1'b0) begin bad++; $display("FAIL raise_early: motor_up=%b exp 0", motor_up); end
    tick();
    total++;
    if ({motor_up, motor_dn, busy} !== 3'b101) begin
      bad++; $display("FAIL raise_on: up/dn/busy=%b exp 101", {motor_up, motor_dn, busy});
    end
    up_limit = 1'b1;
    repeat (DEB + 2) tick();
    total++;
    if (motor_up !== 1'b1) begin bad++; $display("FAIL raise_limit_early: motor_up=%b exp 1", motor_up); end
    tick();
    total++;
    if ({motor_up, busy} !== 2'b00) begin
      bad++; $display("FAIL raise_limit_stop: up/busy=%b exp 00", {motor_up, busy});
    end
  endtask

  task automatic test_lower_bounce();
    pulse_act();
    tick(); tick();
    total++;
    if ({motor_up, motor_dn} !== 2'b01) begin
      bad++; $display("FAIL lower_on: up/dn=%b exp 01", {motor_up, motor_dn});
    end
    up_limit = 1'b0;
    for (int g = 0; g < 2; g++) begin
      dn_limit = 1'b1;
      repeat (DEB - 1) begin
        tick();
        total++;
        if (motor_dn !== 1'b1) begin bad++; $display("FAIL lower_glitch: motor_dn=%b exp 1", motor_dn); end
      end
      dn_limit = 1'b0;
      tick();
      total++;
      if (motor_dn !== 1'b1) begin bad++; $display("FAIL lower_gap: motor_dn=%b exp 1", motor_dn); end
    end
    dn_limit = 1'b1;
    repeat (DEB + 2) tick();
    total++;
    if (motor_dn !== 1'b1) begin bad++; $display("FAIL lower_limit_early: motor_dn=%b exp 1", motor_dn); end
    tick();
    total++;
    if ({motor_dn, busy} !== 2'b00) begin
      bad++; $display("FAIL lower_limit_stop: dn/busy=%b exp 00", {motor_dn, busy});
    end
  endtask

  task automatic test_timeout();
    int cnt;
    dn_limit = 1'b0;
    repeat (8) tick();
    pulse_act();
    tick(); tick();
    cnt = motor_up ? 1 : 0;
    for (int i = 0; i < 3 * TMO; i++) begin
      tick();
      if (motor_up) cnt++;
      else break;
    end
    total++;
    if (cnt != TMO) begin bad++; $display("FAIL timeout_len: high cycles=%0d exp %0d", cnt, TMO); end
    total++;
    if ({fault, fault_code, busy} !== 4'b1010) begin
      bad++; $display("FAIL timeout_fault: fault/code/busy=%b exp 1010", {fault, fault_code, busy});
    end
    clear_fault();
  endtask

  task automatic test_both_limits();
    pulse_act();
    tick(); tick();
    total++;
    if (motor_up !== 1'b1) begin bad++; $display("FAIL both_start: motor_up=%b exp 1", motor_up); end
    up_limit = 1'b1;
    dn_limit = 1'b1;
    repeat (DEB + 2) tick();
    total++;
    if (motor_up !== 1'b1) begin bad++; $display("FAIL both_early: motor_up=%b exp 1", motor_up); end
    tick();
    total++;
    if ({motor_up, fault, fault_code} !== 4'b0110) begin
      bad++; $display("FAIL both_fault: up/fault/code=%b exp 0110", {motor_up, fault, fault_code});
    end
    fault_clr = 1'b1;
    repeat (4) tick();
    total++;
    if ({fault, fault_code} !== 3'b110) begin
      bad++; $display("FAIL both_clr_ignored: fault/code=%b exp 110", {fault, fault_code});
    end
    dn_limit = 1'b0;
    repeat (DEB + 2) tick();
    total++;
    if (fault !== 1'b1) begin bad++; $display("FAIL both_release_early: fault=%b exp 1", fault); end
    tick();
    total++;
    if ({fault, fault_code} !== 3'b000) begin
      bad++; $display("FAIL both_clr_accept: fault/code=%b exp 000", {fault, fault_code});
    end
    fault_clr = 1'b0;
    up_limit = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reversal();
    pulse_act();
    tick(); tick();
    total++;
    if (motor_up !== 1'b1) begin bad++; $display("FAIL rev_start: motor_up=%b exp 1", motor_up); end
    pulse_act();
    tick();
    total++;
    if (motor_up !== 1'b1) begin bad++; $display("FAIL rev_hold: motor_up=%b exp 1", motor_up); end
    for (int i = 0; i < DT; i++) begin
      tick();
      total++;
      if ({motor_up, motor_dn, busy} !== (REV ? 3'b001 : 3'b101)) begin
        bad++; $display("FAIL rev_deadtime[%0d]: up/dn/busy=%b exp %b", i, {motor_up, motor_dn, busy},
                        REV ? 3'b001 : 3'b101);
      end
    end
    tick();
    total++;
    if ({motor_up, motor_dn} !== (REV ? 2'b01 : 2'b10)) begin
      bad++; $display("FAIL rev_new_dir: up/dn=%b exp %b", {motor_up, motor_dn}, REV ? 2'b01 : 2'b10);
    end
    repeat (30) tick();
    total++;
    if ({fault, fault_code} !== 3'b101) begin
      bad++; $display("FAIL rev_timeout: fault/code=%b exp 101", {fault, fault_code});
    end
    clear_fault();
  endtask

  task automatic test_reset_mid();
    up_limit = 1'b1;
    repeat (8) tick();
    pulse_act();
    tick(); tick();
    total++;
    if (motor_dn !== 1'b1) begin bad++; $display("FAIL rstmid_start: motor_dn=%b exp 1", motor_dn); end
    activate = 1'b1;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({motor_up, motor_dn, busy, fault} !== 4'b0000) begin
      bad++; $display("FAIL rstmid_async_drop: up/dn/busy/fault=%b exp 0000", {motor_up, motor_dn, busy, fault});
    end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if ({motor_up, motor_dn, busy} !== 3'b000) begin
        bad++; $display("FAIL rstmid_held_activate[%0d]: up/dn/busy=%b exp 000", i, {motor_up, motor_dn, busy});
      end
    end
    activate = 1'b0;
    up_limit = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_random_soak();
    logic [5:0] exp_v;
    for (int i = 0; i < 2000; i++) begin
      tick();
      exp_v = {m_mode == 1, m_mode == 2, m_mode == 1 || m_mode == 2 || m_mode == 3, m_mode == 4, 2'(m_code)};
      total++;
      if ({motor_up, motor_dn, busy, fault, fault_code} !== exp_v) begin
        bad++; $display("FAIL soak[%0d]: up/dn/busy/fault/code=%b exp %b", i,
                        {motor_up, motor_dn, busy, fault, fault_code}, exp_v);
      end
      total++;
      if ((motor_up & motor_dn) !== 1'b0) begin
        bad++; $display("FAIL soak_exclusive[%0d]: up&dn=%b exp 0", i, motor_up & motor_dn);
      end
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
      if ($urandom_range(0, 5) == 0) activate = ~activate;
      if ($urandom_range(0, 9) == 0) up_limit = ~up_limit;
      if ($urandom_range(0, 9) == 0) dn_limit = ~dn_limit;
      fault_clr = ($urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_raise();
    test_lower_bounce();
    test_timeout();
    test_both_limits();
    test_reversal();
    test_reset_mid();
    test_random_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motor_ctrl.md
# motor_ctrl

Parametrised up/down actuator controller: the next generation of the single-shot motor FSM. It adds synchronised and debounced limit switches, edge-triggered activation, a travel timeout, a both-limits fault and an optional mid-travel reversal through a dead-time stop. It sits between the panel/processor control inputs and the motor driver enables. It guarantees `motor_up` and `motor_dn` are never high together.

## Interface
- `DEBOUNCE`, 4: consecutive cycles a synchronised limit input must differ from its filtered value before the filtered value flips; ≥1.
- `TIMEOUT`, 1000: maximum cycles a motor enable may stay high in one travel; ≥2.
- `DEADTIME`, 8: cycles both enables are held low between opposite directions on reversal; ≥1.
- `clk  in  1  clock; all flops rise-edge.`
- `rst  in  1  asynchronous, active-high reset.`
- `activate  in  1  asynchronous request; rising edge acts.`
- `up_limit  in  1  asynchronous top limit switch, high = at top.`
- `dn_limit  in  1  asynchronous bottom limit switch, high = at bottom.`
- `fault_clr  in  1  synchronous fault clear, level.`
- `motor_up  out  1  raise enable.`
- `motor_dn  out  1  lower enable.`
- `busy  out  1  state is UP, DN or STOP.`
- `fault  out  1  state is FAULT.`
- `fault_code  out  2  00 none, 01 timeout, 10 both limits; held while fault.`

## Operation
- **Input conditioning**
  - `activate`, `up_limit` and `dn_limit` each pass through 2 sync flops, all reset to 0.
  - `act_pulse` is the synchronised `activate` AND NOT its one-cycle-delayed copy. Holding `activate` high never retriggers.
  - Limit filters `up_f` and `dn_f` reset to 0. Each has its own counter, cleared whenever the synchronised value equals the filtered value.
  - When the synchronised value has differed for `DEBOUNCE` consecutive cycles, the filtered value flips.
- **States:** IDLE, UP, DN, STOP, FAULT. Outputs are decoded from the state register (Moore).
  - `motor_up` = UP; `motor_dn` = DN; `busy` = UP|DN|STOP; `fault` = FAULT.
- **Transition priority** within each state, top first:
  - Any state except FAULT, `up_f & dn_f` → FAULT, code 10.
  - IDLE, `act_pulse`: `up_f` → DN, else → UP.
  - UP, `up_f` → IDLE. DN, `dn_f` → IDLE.
  - UP or DN, travel timer = `TIMEOUT-1` → FAULT, code 01.
  - UP or DN, `act_pulse` → STOP with the pending direction set to the opposite one. This path exists only with reversal compiled in (see Configuration).
  - STOP, dead-time counter = `DEADTIME-1` → pending direction state.
  - FAULT, `fault_clr & ~(up_f & dn_f)` → IDLE, code → 00.
- **Counters**
  - Travel timer is `$clog2(TIMEOUT)` bits, cleared on entry to UP/DN and incremented each cycle in UP/DN. A travel never exceeds `TIMEOUT` enable-high cycles.
  - Dead-time counter is `$clog2(DEADTIME+1)` bits, cleared on STOP entry.
- `act_pulse` in STOP or FAULT is ignored and not queued.

## Timing
- **Reset:** all outputs are 0 and state is IDLE. Assertion mid-travel drops `motor_up`/`motor_dn` asynchronously, with no dead-time.
- **`activate` → motor enable:** if `activate` is first sampled high at edge N, the enable is high after edge N+2.
- **Limit → enable low:** if the limit is first sampled at edge N, the enable is low after edge N+`DEBOUNCE`+2.
- **Reversal:** the old enable falls at edge E. Both enables are low for exactly `DEADTIME` cycles. The new enable rises at edge E+`DEADTIME`.
- **Fault clear:** `fault_clr` high at edge N gives IDLE and `fault`=0 after N. A simultaneous `act_pulse` is ignored.

## Configuration
- `MOTOR_CTRL_REVERSE_EN` defined: `act_pulse` in UP/DN causes STOP, dead-time, then the opposite direction.
- Undefined: `act_pulse` in UP/DN is ignored. STOP is unreachable and may be removed. Travel ends only by limit, timeout or fault.

## Test plan
- **Raise:** `DEBOUNCE`=4. Reset, both limits 0, pulse `activate`. `motor_up`=1 two edges after first sample. Drive `up_limit`=1 → `motor_up`=0 exactly 6 edges later, state IDLE.
- **Lower, with bounce:** `up_limit`=1, pulse `activate` → `motor_dn`=1. Toggle `dn_limit` with 3-cycle glitches → no effect. Hold high → `motor_dn`=0.
- **Timeout:** `TIMEOUT`=16, no limits → `motor_up` high exactly 16 cycles, then `fault`=1, `fault_code`=01. `fault_clr` → IDLE, code 00.
- **Both limits:** both limits high mid-travel → FAULT code 10. `fault_clr` ignored while both are filtered high; accepted after one is released.
- **Reversal:** `REVERSE_EN` defined, `DEADTIME`=8, pulse `activate` during UP → 8 cycles both low, then `motor_dn`=1. Undefined: same stimulus leaves `motor_up` high.
- **Reset mid-travel:** `rst` asserted between edges while `motor_dn`=1 → `motor_dn`=0 immediately. After release, state is IDLE and a held-high `activate` does not start motion.
